// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment reader and its forward decoder.
// Holds the blank pattern, the active-low hex glyph table and the
// reader FSM state encoding.
package seg7_pkg;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for digits 0..F; bit0 = segment a, bit6 = segment g.
  localparam logic [6:0] SEG_GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // True when the segment pattern shows nothing at all.
  function automatic logic seg_is_blank(input logic [6:0] pattern);
    return (pattern == SEG_BLANK);
  endfunction

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup: active-low segment pattern -> {valid, digit}.
// Glyphs in the table are unique, so OR-ing every hit yields the single
// matching index without a priority chain.
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] digit
);

  // Search the shared glyph table for the sampled pattern.
  always_comb begin
    valid = 1'b0;
    digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      valid = valid | (pattern == SEG_GLYPHS[i]);
      digit = digit | ({4{pattern == SEG_GLYPHS[i]}} & 4'(i));
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads an active-low 7-segment bus back into a 4-bit hex digit.
// A pattern must be seen on STABLE_CNT consecutive sample strobes before it
// is acted on; qualified digits land in a one-entry valid/ready slot.
// Optional build macro SEG7_READER_DP_EN adds the decimal point (seg_dp in,
// dp_out out), which then takes part in stability and repeat suppression.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic [3:0] hex_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pattern_err,
  output logic       overrun,
  output logic       blank
`ifdef SEG7_READER_DP_EN
  ,
  input  logic       seg_dp,
  output logic       dp_out
`endif
);

`ifdef SEG7_READER_DP_EN
  localparam int PW = 8;
  localparam int KW = 5;
  localparam logic [PW-1:0] PAT_RST = {1'b1, SEG_BLANK};
`else
  localparam int PW = 7;
  localparam int KW = 4;
  localparam logic [PW-1:0] PAT_RST = SEG_BLANK;
`endif

  localparam logic [CNT_W-1:0] STABLE_K = CNT_W'(STABLE_CNT);
  localparam logic             SINGLE   = (STABLE_CNT == 1);

  logic [PW-1:0]    pat_s;
  logic [KW-1:0]    key_s;
  logic             glyph_valid_s;
  logic [3:0]       glyph_digit_s;
  logic             is_blank_s;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [PW-1:0]    cand_r;
  logic [PW-1:0]    cand_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             qualify_s;

  logic             same_s;
  logic             emit_s;
  logic             err_s;
  logic             drain_s;
  logic             load_s;
  logic             drop_s;

  logic [3:0]       hex_r;
  logic             out_valid_r;
  logic             pattern_err_r;
  logic             overrun_r;
  logic             blank_r;
  logic             last_valid_r;
  logic [KW-1:0]    last_key_r;

`ifdef SEG7_READER_DP_EN
  logic             dp_r;
  assign pat_s  = {seg_dp, seg_in};
  // Key carries the point as active-high so a dp change is a new digit.
  assign key_s  = {~seg_dp, glyph_digit_s};
  assign dp_out = dp_r;
`else
  assign pat_s  = seg_in;
  assign key_s  = glyph_digit_s;
`endif

  // The qualified pattern is always the one on seg_in at the qualifying edge.
  seg7_glyph_lookup u_lookup (
    .pattern (pat_s[6:0]),
    .valid   (glyph_valid_s),
    .digit   (glyph_digit_s)
  );

  assign is_blank_s = seg_is_blank(pat_s[6:0]);
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  // Stability tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cand_r  <= PAT_RST;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cand_r  <= cand_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: count identical samples and flag the qualifying one.
  always_comb begin
    state_nxt_s = state_r;
    cand_nxt_s  = cand_r;
    cnt_nxt_s   = cnt_r;
    qualify_s   = 1'b0;
    if (sample_en) begin
      case (state_r)
        IDLE: begin
          cand_nxt_s = pat_s;
          cnt_nxt_s  = CNT_W'(1);
          if (SINGLE) begin
            qualify_s   = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = TRACK;
          end
        end
        TRACK: begin
          if (pat_s == cand_r) begin
            cnt_nxt_s = cnt_inc_s;
            if (cnt_inc_s == STABLE_K) begin
              qualify_s   = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = TRACK;
            end
          end else begin
            cand_nxt_s = pat_s;
            cnt_nxt_s  = CNT_W'(1);
          end
        end
        HOLD: begin
          if (pat_s == cand_r) begin
            state_nxt_s = HOLD;
          end else begin
            cand_nxt_s = pat_s;
            cnt_nxt_s  = CNT_W'(1);
            if (SINGLE) begin
              qualify_s   = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = TRACK;
            end
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cand_nxt_s  = PAT_RST;
          cnt_nxt_s   = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // A repeat of the last emitted digit is a flicker, not a new reading.
  assign same_s  = last_valid_r & (key_s == last_key_r);
  assign emit_s  = qualify_s & ~is_blank_s & glyph_valid_s & ~same_s;
  assign err_s   = qualify_s & ~is_blank_s & ~glyph_valid_s;
  assign drain_s = out_valid_r & out_ready;
  assign load_s  = emit_s & (~out_valid_r | out_ready);
  assign drop_s  = emit_s & out_valid_r & ~out_ready;

  // Output slot, error/overrun flags and last-digit memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_r         <= 4'd0;
      out_valid_r   <= 1'b0;
      pattern_err_r <= 1'b0;
      overrun_r     <= 1'b0;
      blank_r       <= 1'b1;
      last_valid_r  <= 1'b0;
      last_key_r    <= '0;
`ifdef SEG7_READER_DP_EN
      dp_r          <= 1'b0;
`endif
    end else begin
      pattern_err_r <= err_s;

      if (load_s) begin
        hex_r       <= glyph_digit_s;
        out_valid_r <= 1'b1;
`ifdef SEG7_READER_DP_EN
        dp_r        <= ~seg_dp;
`endif
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      if (qualify_s) begin
        if (is_blank_s) begin
          blank_r      <= 1'b1;
          last_valid_r <= 1'b0;
        end else if (glyph_valid_s) begin
          if (!same_s) begin
            blank_r      <= 1'b0;
            last_key_r   <= key_s;
            last_valid_r <= 1'b1;
          end else begin
            last_valid_r <= last_valid_r;
          end
        end else begin
          blank_r      <= 1'b0;
          last_valid_r <= 1'b0;
        end
      end else begin
        blank_r <= blank_r;
      end
    end
  end

  assign hex_out     = hex_r;
  assign out_valid   = out_valid_r;
  assign pattern_err = pattern_err_r;
  assign overrun     = overrun_r;
  assign blank       = blank_r;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CNT = 3, no dp).
module tb_seg7_reader;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       sample_en;
  logic [3:0] hex_out;
  logic       out_valid;
  logic       out_ready;
  logic       pattern_err;
  logic       overrun;
  logic       blank;

  int checks;
  int failures;
  int xfer_cnt;
  int err_cnt;
  logic [3:0] last_xfer;
  int xfer_base;
  int err_base;

  // Hand-written glyph constants, index = digit.
  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_reader #(.STABLE_CNT(3), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .sample_en   (sample_en),
    .hex_out     (hex_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pattern_err (pattern_err),
    .overrun     (overrun),
    .blank       (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed transfers and error pulses.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_xfer = hex_out;
    end
    if (rst_n && pattern_err) begin
      err_cnt = err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample strobe; call at a falling edge, returns at the next one.
  task automatic strobe(input logic [6:0] p);
    seg_in    = p;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic strobe_n(input logic [6:0] p, input int n);
    for (int k = 0; k < n; k++) strobe(p);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    xfer_cnt  = 0;
    err_cnt   = 0;
    last_xfer = 4'd0;
    rst_n     = 1'b0;
    seg_in    = 7'h7F;
    sample_en = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_hex",     {28'd0, hex_out}, 32'd0);
    check("rst_valid",   {31'd0, out_valid}, 32'd0);
    check("rst_err",     {31'd0, pattern_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_blank",   {31'd0, blank}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Digit 2 after exactly three strobes.
    strobe(7'h24);
    strobe(7'h24);
    check("t1_not_yet", {31'd0, out_valid}, 32'd0);
    strobe(7'h24);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_hex",   {28'd0, hex_out}, 32'd2);
    check("t1_blank", {31'd0, blank}, 32'd0);
    @(negedge clk);
    check("t1_drop",  {31'd0, out_valid}, 32'd0);
    check("t1_xfers", xfer_cnt, 32'd1);

    // Every glyph in turn.
    for (int i = 0; i < 16; i++) begin
      strobe_n(glyph_tab[i], 3);
      check($sformatf("glyph_%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("glyph_%0d_hex", i), {28'd0, hex_out}, i);
    end
    @(negedge clk);

    // Short 2 run never qualifies; only 3 is emitted.
    xfer_base = xfer_cnt;
    strobe(7'h24); strobe(7'h24);
    strobe(7'h30); strobe(7'h30); strobe(7'h30);
    @(negedge clk);
    check("t2_xfers", xfer_cnt - xfer_base, 32'd1);
    check("t2_digit", {28'd0, last_xfer}, 32'd3);

    // Long F hold emits once; blank, then F again.
    xfer_base = xfer_cnt;
    strobe_n(7'h0E, 10);
    @(negedge clk);
    check("t3_one_f", xfer_cnt - xfer_base, 32'd1);
    check("t3_f",     {28'd0, last_xfer}, 32'd15);
    strobe_n(7'h7F, 3);
    @(negedge clk);
    check("t3_blank",   {31'd0, blank}, 32'd1);
    check("t3_no_emit", xfer_cnt - xfer_base, 32'd1);
    strobe_n(7'h0E, 3);
    check("t3_unblank", {31'd0, blank}, 32'd0);
    @(negedge clk);
    check("t3_f_again", xfer_cnt - xfer_base, 32'd2);

    // Invalid pattern pulses pattern_err for one cycle.
    xfer_base = xfer_cnt;
    err_base  = err_cnt;
    strobe_n(7'h55, 3);
    check("t4_err",     {31'd0, pattern_err}, 32'd1);
    check("t4_novalid", {31'd0, out_valid}, 32'd0);
    check("t4_blank",   {31'd0, blank}, 32'd0);
    @(negedge clk);
    check("t4_err_off", {31'd0, pattern_err}, 32'd0);
    check("t4_errs",    err_cnt - err_base, 32'd1);
    check("t4_noxfer",  xfer_cnt - xfer_base, 32'd0);

    // Full slot: second digit is dropped and overrun sticks.
    out_ready = 1'b0;
    xfer_base = xfer_cnt;
    strobe_n(7'h79, 3);
    check("t5_valid1", {31'd0, out_valid}, 32'd1);
    check("t5_hex1",   {28'd0, hex_out}, 32'd1);
    check("t5_no_ovr", {31'd0, overrun}, 32'd0);
    strobe_n(7'h78, 3);
    check("t5_hold",    {28'd0, hex_out}, 32'd1);
    check("t5_overrun", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_drained", {31'd0, out_valid}, 32'd0);
    check("t5_xfers",   xfer_cnt - xfer_base, 32'd1);
    check("t5_digit",   {28'd0, last_xfer}, 32'd1);
    check("t5_sticky",  {31'd0, overrun}, 32'd1);

    // Asynchronous reset with a pending digit, mid-TRACK.
    out_ready = 1'b0;
    strobe_n(7'h46, 3);
    check("t6_pending", {31'd0, out_valid}, 32'd1);
    check("t6_hex_c",   {28'd0, hex_out}, 32'd12);
    strobe(7'h24);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid",   {31'd0, out_valid}, 32'd0);
    check("t6_rst_hex",     {28'd0, hex_out}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    check("t6_rst_blank",   {31'd0, blank}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    strobe(7'h40);
    strobe(7'h40);
    check("t6_not_yet", {31'd0, out_valid}, 32'd0);
    strobe(7'h40);
    check("t6_valid0", {31'd0, out_valid}, 32'd1);
    check("t6_hex0",   {28'd0, hex_out}, 32'd0);
    @(negedge clk);
    check("t6_drop", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Inverse of the hex-to-7-segment decoder: samples an active-low 7-segment pattern bus and recovers the 4-bit hex digit it shows.
- Used to read back a driven display or to capture segment lines from an external board into the datapath for self-check and loopback tests.
- Filters glitches by requiring a stable pattern over several sample strobes.
- Flags patterns that are not in the hex glyph set.
- Delivers digits through a one-entry valid/ready output slot.

Parameters:
- STABLE_CNT, 3, consecutive identical samples needed to qualify a pattern (legal range 1..15).
- CNT_W, 4, width of the stability counter (must hold STABLE_CNT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  active-low segments; bit0=a … bit6=g.
- sample_en  in  1  sample strobe; seg_in is considered only on cycles where this is 1.
- hex_out  out  4  recovered digit; stable while out_valid=1.
- out_valid  out  1  digit available in the output slot.
- out_ready  in  1  consumer accepts; transfer occurs on a cycle where out_valid & out_ready.
- pattern_err  out  1  one-cycle pulse: qualified pattern is not a hex glyph and not blank.
- overrun  out  1  sticky; set when a new digit qualifies while the slot is full; cleared only by reset.
- blank  out  1  level; the last qualified pattern was 7'h7F (all segments off).

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, cand=7'h7F, hex_out=0, out_valid=0, pattern_err=0, overrun=0, blank=1, last_valid=0.
- Glyph table (seg_in hex -> digit), exact:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
- Any other pattern except 7F is invalid.
- FSM states IDLE, TRACK, HOLD. All transitions happen only on sample_en=1 cycles; otherwise all state is held.
  - IDLE: cand<=seg_in, cnt<=1. If STABLE_CNT==1, qualify and go to HOLD; else go to TRACK.
  - TRACK: if seg_in==cand, cnt<=cnt+1; when cnt+1==STABLE_CNT, qualify and go to HOLD. If seg_in!=cand, cand<=seg_in, cnt<=1, stay in TRACK.
  - HOLD: if seg_in==cand, no action (no re-emit). If different, cand<=seg_in, cnt<=1, go to TRACK (or qualify immediately and stay in HOLD if STABLE_CNT==1).
- Qualify actions (registered; visible the cycle after the qualifying edge):
  - cand==7F: blank<=1, last_valid<=0, no emit.
  - Valid glyph and (last_valid=0 or digit!=last_digit): emit. blank<=0, last_digit<=digit, last_valid<=1.
  - Valid glyph equal to last_digit with last_valid=1: no emit (a flicker back to the same digit is suppressed).
  - Invalid: pattern_err pulses 1 cycle, blank<=0, last_valid<=0, no emit.
- Emit:
  - Slot empty, or draining this same cycle (out_valid & out_ready): hex_out<=digit, out_valid<=1.
  - Otherwise: digit dropped, slot unchanged, overrun<=1.
- Latency: out_valid rises 1 clk after the edge carrying the STABLE_CNT-th matching sample.
- out_valid falls the cycle after the transfer unless it is reloaded that same cycle.
- hex_out must not change while out_valid=1 and out_ready=0.
- Reset mid-operation clears everything, including a pending slot; the first qualified digit after reset always emits.

Optional Feature:
- SEG7_READER_DP_EN defined:
  - adds input seg_dp (1 bit, active-low) and output dp_out (1 bit).
  - the compared pattern becomes 8 bits, so a dp change restarts stability counting.
  - dp_out is loaded alongside hex_out, active-high (1 = point lit).
  - the digit compare for emit suppression includes dp.
- Undefined: no dp ports; a 7-bit pattern as above.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK=7'h7F;
  - the 16-entry glyph constant array (shared with the forward decoder);
  - the state enum {IDLE,TRACK,HOLD}.
- One natural sub-module, seg7_glyph_lookup: combinational pattern -> {valid, digit}; it searches the package array.

Test Plan:
- STABLE_CNT=3; seg_in=7'h24 for 3 strobes, out_ready=1 -> out_valid pulses once, hex_out=2, 1 clk after the 3rd strobe.
- 24,24,30,30,30 -> only digit 3 emitted; the 24 run never qualifies.
- 0E held for 10 strobes -> exactly one emit of F. Then 7F x3 -> blank=1, no emit. Then 0E x3 -> F emitted again.
- seg_in=7'h55 x3 -> pattern_err 1-cycle pulse, no out_valid, blank=0.
- out_ready=0; qualify 1 (79), then 7 (78) -> hex_out stays 1, overrun=1. Raise out_ready -> one transfer, out_valid drops.
- rst_n low asynchronously mid-TRACK with out_valid=1 -> all outputs at reset values immediately. After release, 40 x3 -> digit 0 emitted.
